// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ADD/SUB/OR/AND/SLT, iterative shift-add MUL and
// restoring DIV over WIDTH cycles, with start/done handshake and registered outputs.
module alu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] OP1,
   input  logic [WIDTH-1:0] OP2,
   input  logic [2:0]       ALUSel,
   output logic [WIDTH-1:0] Res,
   output logic             Z,
   output logic             Err,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             z_q, z_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] mul_sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_sub;
   logic             last;
   logic             op_err;

   // a_q holds multiplicand (MUL) or divisor (DIV); b_q holds multiplier or
   // dividend/quotient shift register; acc_q holds partial product or remainder.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      res_d   = res_q;
      z_d     = z_q;
      err_d   = err_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      op_err  = 1'b0;
      mul_sum = acc_q + (b_q[0] ? a_q : '0);
      rem_sh  = {acc_q, b_q[WIDTH-1]};
      rem_sub = rem_sh - {1'b0, a_q};
      last    = (cnt_q == CW'(WIDTH - 1));

      case (state_q)
         S_IDLE: begin
            if (start) begin
               done_d = 1'b1;
               case (ALUSel)
                  3'b000: res_d = OP1 + OP2;
                  3'b001: res_d = OP1 - OP2;
                  3'b100: res_d = OP1 | OP2;
                  3'b101: res_d = OP1 & OP2;
                  3'b110: res_d = WIDTH'(OP1 < OP2);
                  3'b010: begin
                     done_d  = 1'b0;
                     state_d = S_MUL;
                     busy_d  = 1'b1;
                     cnt_d   = '0;
                     a_d     = OP1;
                     b_d     = OP2;
                     acc_d   = '0;
                  end
                  3'b011: begin
                     if (OP2 == '0) begin
                        res_d  = '1;
                        op_err = 1'b1;
                     end else begin
                        done_d  = 1'b0;
                        state_d = S_DIV;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        a_d     = OP2;
                        b_d     = OP1;
                        acc_d   = '0;
                     end
                  end
                  default: begin
                     res_d  = '0;
                     op_err = 1'b1;
                  end
               endcase
            end
         end
         S_MUL: begin
            acc_d = mul_sum;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               res_d   = mul_sum;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_DIV: begin
            // Borrow out of the trial subtraction means restore the shifted remainder
            if (!rem_sub[WIDTH]) begin
               acc_d = rem_sub[WIDTH-1:0];
               b_d   = {b_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = rem_sh[WIDTH-1:0];
               b_d   = {b_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               res_d   = b_d;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (done_d) begin
         err_d = op_err;
         z_d   = (res_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         z_q     <= 1'b1;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         z_q     <= z_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Res  = res_q;
   assign Z    = z_q;
   assign Err  = err_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=32 and WIDTH=8: transaction-level model checked every
// cycle, plus directed vectors with hand-computed results and latencies.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  st_i;
   logic [2:0]  sel [2];
   logic [63:0] a_in [2];
   logic [63:0] b_in [2];
   logic [31:0] res32;
   logic [7:0]  res8;
   logic [1:0]  z_o, err_o, busy_o, done_o;
   logic [63:0] got_res [2];

   int total = 0;
   int bad   = 0;

   int          m_pend [2];
   logic [63:0] p_res [2];
   logic        p_err [2];
   logic [63:0] e_res [2];
   logic        e_z [2], e_err [2], e_done [2], e_busy [2];
   logic        started = 1'b0;
   int          m_w;
   logic [64:0] m_r;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(32)) u_w32 (
      .clk(clk), .rst(rst), .start(st_i[0]),
      .OP1(a_in[0][31:0]), .OP2(b_in[0][31:0]), .ALUSel(sel[0]),
      .Res(res32), .Z(z_o[0]), .Err(err_o[0]), .busy(busy_o[0]), .done(done_o[0])
   );

   alu_seq #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .start(st_i[1]),
      .OP1(a_in[1][7:0]), .OP2(b_in[1][7:0]), .ALUSel(sel[1]),
      .Res(res8), .Z(z_o[1]), .Err(err_o[1]), .busy(busy_o[1]), .done(done_o[1])
   );

   always_comb begin
      got_res[0] = {32'd0, res32};
      got_res[1] = {56'd0, res8};
   end

   function automatic logic [64:0] model_op(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input int w);
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      case (op)
         3'd0: return {1'b0, (a + b) & m};
         3'd1: return {1'b0, (a - b) & m};
         3'd2: return {1'b0, (a * b) & m};
         3'd3: return (b == 64'd0) ? {1'b1, m} : {1'b0, a / b};
         3'd4: return {1'b0, a | b};
         3'd5: return {1'b0, a & b};
         3'd6: return {1'b0, (a < b) ? 64'd1 : 64'd0};
         default: return {1'b1, 64'd0};
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // Transaction model: an accepted request yields its result after its latency
   always @(posedge clk) begin
      started = 1'b1;
      for (int d = 0; d < 2; d++) begin
         m_w = (d == 0) ? 32 : 8;
         if (rst) begin
            m_pend[d] = 0;
            e_res[d]  = 64'd0;
            e_z[d]    = 1'b1;
            e_err[d]  = 1'b0;
            e_done[d] = 1'b0;
            e_busy[d] = 1'b0;
         end else begin
            e_done[d] = 1'b0;
            if (m_pend[d] > 0) begin
               m_pend[d]--;
            end else if (st_i[d]) begin
               m_r      = model_op(sel[d], a_in[d], b_in[d], m_w);
               p_err[d] = m_r[64];
               p_res[d] = m_r[63:0];
               m_pend[d] = (sel[d] == 3'd2 || (sel[d] == 3'd3 && b_in[d] != 64'd0)) ? m_w + 1 : 1;
               m_pend[d]--;
               if (m_pend[d] == 0) m_pend[d] = -1;
            end
            if (m_pend[d] <= 0 && (m_pend[d] == -1 || (m_pend[d] == 0 && e_busy[d]))) begin
               m_pend[d] = 0;
               e_res[d]  = p_res[d];
               e_err[d]  = p_err[d];
               e_z[d]    = (p_res[d] == 64'd0);
               e_done[d] = 1'b1;
            end
            e_busy[d] = (m_pend[d] > 0);
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("w%0d_res", (d == 0) ? 32 : 8), got_res[d], e_res[d]);
            chk($sformatf("w%0d_z", (d == 0) ? 32 : 8), {63'd0, z_o[d]}, {63'd0, e_z[d]});
            chk($sformatf("w%0d_err", (d == 0) ? 32 : 8), {63'd0, err_o[d]}, {63'd0, e_err[d]});
            chk($sformatf("w%0d_busy", (d == 0) ? 32 : 8), {63'd0, busy_o[d]}, {63'd0, e_busy[d]});
            chk($sformatf("w%0d_done", (d == 0) ? 32 : 8), {63'd0, done_o[d]}, {63'd0, e_done[d]});
         end
      end
   end

   task automatic go(input int d, input logic [2:0] op, input logic [63:0] a,
                     input logic [63:0] b, output int lat);
      sel[d]  = op;
      a_in[d] = a;
      b_in[d] = b;
      st_i[d] = 1'b1;
      @(posedge clk); #1;
      st_i[d] = 1'b0;
      lat = 1;
      while (!done_o[d] && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      int ndone;
      st_i = 2'b00;
      for (int d = 0; d < 2; d++) begin
         sel[d]  = 3'd0;
         a_in[d] = 64'd0;
         b_in[d] = 64'd0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_res", res32, 64'd0);
      chk("rst_z", z_o[0], 64'd1);
      chk("rst_err", err_o[0], 64'd0);
      chk("rst_busy", busy_o[0], 64'd0);
      chk("rst_done", done_o[0], 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      go(0, 3'd0, 64'hFFFF_FFFF, 64'd1, lat);
      chk("add_lat", lat, 64'd1);
      chk("add_res", res32, 64'd0);
      chk("add_z", z_o[0], 64'd1);
      go(0, 3'd1, 64'd5, 64'd7, lat);
      chk("sub_res", res32, 64'hFFFF_FFFE);
      chk("sub_z", z_o[0], 64'd0);
      go(0, 3'd6, 64'd3, 64'd4, lat);
      chk("slt34_res", res32, 64'd1);
      go(0, 3'd6, 64'd4, 64'd3, lat);
      chk("slt43_res", res32, 64'd0);
      chk("slt43_z", z_o[0], 64'd1);
      go(0, 3'd3, 64'd100, 64'd7, lat);
      chk("div_lat", lat, 64'd33);
      chk("div_res", res32, 64'd14);
      chk("div_err", err_o[0], 64'd0);
      go(0, 3'd3, 64'd5, 64'd0, lat);
      chk("div0_lat", lat, 64'd1);
      chk("div0_res", res32, 64'hFFFF_FFFF);
      chk("div0_err", err_o[0], 64'd1);
      chk("div0_z", z_o[0], 64'd0);
      go(0, 3'd7, 64'd9, 64'd9, lat);
      chk("rsv_res", res32, 64'd0);
      chk("rsv_err", err_o[0], 64'd1);
      chk("rsv_z", z_o[0], 64'd1);

      // MUL with operand changes and ignored start pulses while busy
      sel[0] = 3'd2; a_in[0] = 64'h10000; b_in[0] = 64'h10003; st_i[0] = 1'b1;
      @(posedge clk); #1;
      st_i[0] = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         chk("mul_busy", busy_o[0], 64'd1);
         chk("mul_nodone", done_o[0], 64'd0);
         if (c == 2) begin
            sel[0] = 3'd4; a_in[0] = 64'hF0; b_in[0] = 64'h0F; st_i[0] = 1'b1;
         end
         @(posedge clk); #1;
      end
      chk("mul_done", done_o[0], 64'd1);
      chk("mul_busy_end", busy_o[0], 64'd0);
      chk("mul_res", res32, 64'h0003_0000);
      @(posedge clk); #1;
      st_i[0] = 1'b0;
      chk("or_done", done_o[0], 64'd1);
      chk("or_res", res32, 64'hFF);
      repeat (3) begin
         @(posedge clk); #1;
         chk("hold_res", res32, 64'hFF);
         chk("hold_done", done_o[0], 64'd0);
      end

      // Reset during a MUL at cycle 10
      sel[0] = 3'd2; a_in[0] = 64'd3; b_in[0] = 64'd5; st_i[0] = 1'b1;
      @(posedge clk); #1;
      st_i[0] = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_res", res32, 64'd0);
      chk("abort_z", z_o[0], 64'd1);
      chk("abort_busy", busy_o[0], 64'd0);
      chk("abort_done", done_o[0], 64'd0);
      ndone = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done_o[0]) ndone++;
      end
      chk("abort_nodone", ndone, 64'd0);

      go(1, 3'd2, 64'd16, 64'd17, lat);
      chk("w8_mul_lat", lat, 64'd9);
      chk("w8_mul_res", res8, 64'h10);
      go(1, 3'd3, 64'd255, 64'd16, lat);
      chk("w8_div_lat", lat, 64'd9);
      chk("w8_div_res", res8, 64'd15);
      repeat (2) @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the datapath's combinational ALU. It performs ADD, SUB, OR, AND and SLT in one cycle, and unsigned MUL and DIV iteratively over WIDTH cycles. It uses a start/done handshake and registered result and flag outputs. It sits between the register-file read stage and the write-back stage; the control unit stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand and result width in bits. Must be at least 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  request; sampled only when `busy`=0.
- `OP1`  in  WIDTH  operand 1; captured at the accepted `start`.
- `OP2`  in  WIDTH  operand 2; captured at the accepted `start`.
- `ALUSel`  in  3  operation select; captured at the accepted `start`.
- `Res`  out  WIDTH  registered result; held until the next `done`.
- `Z`  out  1  result-is-zero flag; updated together with `Res`.
- `Err`  out  1  error flag: division by zero or reserved opcode; updated with `Res`.
- `busy`  out  1  an iterative operation is in progress.
- `done`  out  1  one-cycle pulse marking the cycle in which a new `Res`/`Z`/`Err` becomes valid.

## Operation
- Encoding of `ALUSel`:
  - 000 ADD
  - 001 SUB
  - 010 MUL
  - 011 DIV
  - 100 OR
  - 101 AND
  - 110 SLT
  - 111 reserved
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^WIDTH.
  - MUL returns the low WIDTH bits of the unsigned product.
  - DIV returns the unsigned quotient, floor(OP1/OP2).
  - SLT is an unsigned compare; `Res` = 1 if OP1 < OP2, else 0, zero-extended.
- `Z` = (`Res` == 0) for every operation, including error results.
- DIV with OP2 == 0 completes with single-cycle latency: `Res` = all ones, `Err` = 1, `Z` = 0.
- Reserved opcode 111 completes with single-cycle latency: `Res` = 0, `Err` = 1, `Z` = 1.
- `Err` = 0 for all other operations.
- FSM states:
  - IDLE: `busy`=0. On `start`: a single-cycle op writes the outputs and pulses `done`, staying in IDLE. MUL goes to MUL. DIV with OP2 != 0 goes to DIV.
  - MUL: shift-add, one partial-product bit per cycle, WIDTH iterations, using an internal counter. On the last iteration, write the outputs, pulse `done`, and return to IDLE.
  - DIV: restoring division, one quotient bit per cycle, WIDTH iterations. On the last iteration, write the outputs, pulse `done`, and return to IDLE.
- The iteration counter is clog2(WIDTH)+1 bits wide and resets to 0 on entry to MUL or DIV.
- Operands are latched at acceptance. Changes on `OP1`, `OP2` or `ALUSel` after acceptance have no effect.
- `start` while `busy`=1 is ignored and is not queued.
- `start` in the same cycle as `done` with `busy`=0 is accepted, giving back-to-back operation.
- `Res`, `Z` and `Err` do not change between `done` pulses.

## Timing
- Reset values: `Res` = 0, `Z` = 1, `Err` = 0, `busy` = 0, `done` = 0, FSM = IDLE, counter = 0.
- Reset mid-operation aborts the operation, returns all outputs to their reset values on that edge, and produces no `done` for the aborted operation.
- Reset has priority over `start`.
- Latency is counted from the cycle in which `start` is sampled high (cycle 0):
  - Single-cycle ops, DIV-by-zero and reserved opcode: `done` and new outputs in cycle 1.
  - MUL and DIV: `busy`=1 in cycles 1..WIDTH; `done`=1 and new outputs in cycle WIDTH+1, when `busy`=0.
- Throughput:
  - One single-cycle op per clock.
  - One MUL/DIV per WIDTH+1 clocks, with the next `start` allowed in the `done` cycle.
- `done` is never high for two consecutive cycles from a single request. Consecutive `done` pulses occur only for back-to-back accepted requests.

## Test plan
- Reset, then idle: `Res`=0, `Z`=1, `Err`=0, `busy`=0, `done`=0. Assert `rst` during a MUL at cycle 10: all outputs return to reset values and no `done` appears.
- ADD 0xFFFFFFFF + 1 -> `Res`=0, `Z`=1, `done` in cycle 1. SUB 5 − 7 -> `Res`=0xFFFFFFFE, `Z`=0. SLT 3,4 -> `Res`=1. SLT 4,3 -> `Res`=0, `Z`=1.
- MUL 0x10000 × 0x10003 -> `Res`=0x00030000. `busy` high in cycles 1..32, `done` only in cycle 33. Operands changed at cycle 2 do not affect the result.
- DIV 100 / 7 -> `Res`=14, `done` in cycle 33. DIV 5 / 0 -> `Res`=0xFFFFFFFF, `Err`=1, `Z`=0, `done` in cycle 1. `ALUSel`=111 -> `Res`=0, `Err`=1, `Z`=1.
- `start` pulses during MUL `busy` are ignored. `start` with OR 0xF0 | 0x0F in the MUL `done` cycle -> `Res`=0xFF with `done` on the next cycle. Result values, `Z` and `Err` are held unchanged between `done` pulses.
- With `WIDTH`=8: MUL 16 × 17 -> `Res`=0x10 and `done` in cycle 9. DIV 255 / 16 -> `Res`=15.
